spi_xfer_sequencer: RTL

Command sequencer that sits directly upstream of spi_top and drives its master-side request interface. It buffers SPI transfer commands from a valid/ready stream and issues them to spi_top one at a time, pulsing req, wait_duration and din_master. It waits for done_tx/done_rx, then returns the received master byte (dout_master) on a response stream, with a timeout guard against a hung transfer.

---
 rtl/spi_xfer_sequencer_if.sv | 41 ++++
 rtl/spi_xfer_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_sequencer_if.sv
// Bundle of the command stream, response stream and spi_top request-side signals
// used by spi_xfer_sequencer. The slave modport is the sequencer's view; the
// master modport is the view of whatever feeds commands and models spi_top.
interface spi_xfer_sequencer_if #(
    parameter int SPI_TRF_BIT = 8
);
    // command stream
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [1:0]             cmd_mode;
    logic [SPI_TRF_BIT-1:0] cmd_data;
    logic [7:0]             cmd_wait;
    // response stream
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [SPI_TRF_BIT-1:0] rsp_data;
    logic                   rsp_err;
    // spi_top master-side request interface
    logic [1:0]             req;
    logic [7:0]             wait_duration;
    logic [SPI_TRF_BIT-1:0] din_master;
    logic [SPI_TRF_BIT-1:0] dout_master;
    logic                   done_tx;
    logic                   done_rx;
    // status
    logic                   busy;

    modport slave (
        input  cmd_valid, cmd_mode, cmd_data, cmd_wait, rsp_ready,
               dout_master, done_tx, done_rx,
        output cmd_ready, rsp_valid, rsp_data, rsp_err,
               req, wait_duration, din_master, busy
    );

    modport master (
        output cmd_valid, cmd_mode, cmd_data, cmd_wait, rsp_ready,
               dout_master, done_tx, done_rx,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err,
               req, wait_duration, din_master, busy
    );
endinterface

// File: rtl/spi_xfer_sequencer.sv
// Command sequencer in front of spi_top: queues commands, issues one req pulse
// per command, waits for the done rising edges (with a timeout guard) and
// queues the captured master byte as a response.
module spi_xfer_sequencer #(
    parameter int SPI_TRF_BIT    = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_xfer_sequencer_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CMD_W = 2 + 8 + SPI_TRF_BIT;
    localparam int RSP_W = 1 + SPI_TRF_BIT;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_PUSH  = 2'd3
    } state_e;

    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e state_q, state_d;

    logic [CMD_W-1:0] cmd_mem_q [FIFO_DEPTH];
    logic [CMD_W-1:0] cmd_mem_d [FIFO_DEPTH];
    logic [PTR_W:0]   cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
    logic [RSP_W-1:0] rsp_mem_q [FIFO_DEPTH];
    logic [RSP_W-1:0] rsp_mem_d [FIFO_DEPTH];
    logic [PTR_W:0]   rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;

    logic [1:0]             mode_q, mode_d;
    logic [SPI_TRF_BIT-1:0] din_q, din_d;
    logic [7:0]             wait_q, wait_d;
    logic [1:0]             req_q, req_d;
    logic                   done_tx_q, done_tx_d, done_rx_q, done_rx_d;
    logic                   lat_tx_q, lat_tx_d, lat_rx_q, lat_rx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_q, err_d;

    logic                   cmd_empty_s, cmd_full_s, rsp_empty_s, rsp_full_s;
    logic                   cmd_push_s, cmd_pop_s, rsp_push_s, rsp_pop_s;
    logic [CMD_W-1:0]       cmd_head_s;
    logic [1:0]             head_mode_s;
    logic [RSP_W-1:0]       rsp_head_s, rsp_push_data_s;
    logic                   rise_tx_s, rise_rx_s, done_ok_s, timeout_s;

    // FIFO status, head entries and done edge detection
    assign cmd_empty_s = (cmd_wr_q == cmd_rd_q);
    assign cmd_full_s  = (cmd_wr_q[PTR_W] != cmd_rd_q[PTR_W]) &&
                         (cmd_wr_q[PTR_W-1:0] == cmd_rd_q[PTR_W-1:0]);
    assign rsp_empty_s = (rsp_wr_q == rsp_rd_q);
    assign rsp_full_s  = (rsp_wr_q[PTR_W] != rsp_rd_q[PTR_W]) &&
                         (rsp_wr_q[PTR_W-1:0] == rsp_rd_q[PTR_W-1:0]);
    assign cmd_head_s  = cmd_mem_q[cmd_rd_q[PTR_W-1:0]];
    assign head_mode_s = cmd_head_s[CMD_W-1 -: 2];
    assign rsp_head_s  = rsp_mem_q[rsp_rd_q[PTR_W-1:0]];
    assign cmd_push_s  = bus.cmd_valid && !cmd_full_s;
    assign rsp_pop_s   = !rsp_empty_s && bus.rsp_ready;
    assign rise_tx_s   = bus.done_tx && !done_tx_q;
    assign rise_rx_s   = bus.done_rx && !done_rx_q;
    assign timeout_s   = (cnt_q == CNT_LAST);

    // A rise in the current cycle counts toward completion so PUSH follows it directly
    always_comb begin
        done_ok_s = 1'b0;
        case (mode_q)
            2'b01:   done_ok_s = lat_tx_q || rise_tx_s;
            2'b10:   done_ok_s = lat_rx_q || rise_rx_s;
            2'b11:   done_ok_s = (lat_tx_q || rise_tx_s) && (lat_rx_q || rise_rx_s);
            default: done_ok_s = 1'b0;
        endcase
    end

    assign bus.cmd_ready     = !cmd_full_s;
    assign bus.rsp_valid     = !rsp_empty_s;
    assign bus.rsp_data      = rsp_head_s[SPI_TRF_BIT-1:0];
    assign bus.rsp_err       = rsp_head_s[RSP_W-1];
    assign bus.req           = req_q;
    assign bus.wait_duration = wait_q;
    assign bus.din_master    = din_q;
    assign bus.busy          = (state_q != ST_IDLE) || !cmd_empty_s;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; completion takes priority over timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!cmd_empty_s && (head_mode_s != 2'b00) && !rsp_full_s) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (done_ok_s || timeout_s) begin
                    state_d = ST_PUSH;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_PUSH: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: command pop, transfer registers, done latches, timeout counter, response push
    always_comb begin
        cmd_pop_s       = 1'b0;
        rsp_push_s      = 1'b0;
        rsp_push_data_s = {RSP_W{1'b0}};
        req_d           = 2'b00;
        mode_d          = mode_q;
        din_d           = din_q;
        wait_d          = wait_q;
        lat_tx_d        = lat_tx_q;
        lat_rx_d        = lat_rx_q;
        cnt_d           = cnt_q;
        err_d           = err_q;
        done_tx_d       = bus.done_tx;
        done_rx_d       = bus.done_rx;
        case (state_q)
            ST_IDLE: begin
                // no-ops are dropped even when the response FIFO is full
                if (!cmd_empty_s && ((head_mode_s == 2'b00) || !rsp_full_s)) begin
                    cmd_pop_s = 1'b1;
                    if (head_mode_s != 2'b00) begin
                        req_d  = head_mode_s;
                        mode_d = head_mode_s;
                        wait_d = cmd_head_s[SPI_TRF_BIT +: 8];
                        din_d  = cmd_head_s[SPI_TRF_BIT-1:0];
                    end else begin
                        req_d  = 2'b00;
                    end
                end else begin
                    cmd_pop_s = 1'b0;
                end
            end
            ST_ISSUE: begin
                lat_tx_d = rise_tx_s;
                lat_rx_d = rise_rx_s;
                cnt_d    = {CNT_W{1'b0}};
                err_d    = 1'b0;
            end
            ST_WAIT: begin
                lat_tx_d = lat_tx_q || rise_tx_s;
                lat_rx_d = lat_rx_q || rise_rx_s;
                cnt_d    = cnt_q + CNT_ONE;
                err_d    = !done_ok_s && timeout_s;
            end
            ST_PUSH: begin
                if (err_q) begin
                    rsp_push_s      = 1'b1;
                    rsp_push_data_s = {1'b1, {SPI_TRF_BIT{1'b0}}};
                end else if (mode_q[1]) begin
                    rsp_push_s      = 1'b1;
                    rsp_push_data_s = {1'b0, bus.dout_master};
                end else begin
                    rsp_push_s      = 1'b0;
                end
            end
            default: begin
                req_d = 2'b00;
            end
        endcase
    end

    // Next-state values of both FIFOs (memory and pointers)
    always_comb begin
        cmd_mem_d = cmd_mem_q;
        rsp_mem_d = rsp_mem_q;
        if (cmd_push_s) begin
            cmd_mem_d[cmd_wr_q[PTR_W-1:0]] = {bus.cmd_mode, bus.cmd_wait, bus.cmd_data};
            cmd_wr_d = cmd_wr_q + PTR_ONE;
        end else begin
            cmd_wr_d = cmd_wr_q;
        end
        if (cmd_pop_s) begin
            cmd_rd_d = cmd_rd_q + PTR_ONE;
        end else begin
            cmd_rd_d = cmd_rd_q;
        end
        if (rsp_push_s) begin
            rsp_mem_d[rsp_wr_q[PTR_W-1:0]] = rsp_push_data_s;
            rsp_wr_d = rsp_wr_q + PTR_ONE;
        end else begin
            rsp_wr_d = rsp_wr_q;
        end
        if (rsp_pop_s) begin
            rsp_rd_d = rsp_rd_q + PTR_ONE;
        end else begin
            rsp_rd_d = rsp_rd_q;
        end
    end

    // Datapath and FIFO registers; memories are cleared so rsp_data reads 0 after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                cmd_mem_q[i] <= {CMD_W{1'b0}};
                rsp_mem_q[i] <= {RSP_W{1'b0}};
            end
            cmd_wr_q  <= {(PTR_W+1){1'b0}};
            cmd_rd_q  <= {(PTR_W+1){1'b0}};
            rsp_wr_q  <= {(PTR_W+1){1'b0}};
            rsp_rd_q  <= {(PTR_W+1){1'b0}};
            mode_q    <= 2'b00;
            din_q     <= {SPI_TRF_BIT{1'b0}};
            wait_q    <= 8'h00;
            req_q     <= 2'b00;
            done_tx_q <= 1'b0;
            done_rx_q <= 1'b0;
            lat_tx_q  <= 1'b0;
            lat_rx_q  <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
            err_q     <= 1'b0;
        end else begin
            cmd_mem_q <= cmd_mem_d;
            rsp_mem_q <= rsp_mem_d;
            cmd_wr_q  <= cmd_wr_d;
            cmd_rd_q  <= cmd_rd_d;
            rsp_wr_q  <= rsp_wr_d;
            rsp_rd_q  <= rsp_rd_d;
            mode_q    <= mode_d;
            din_q     <= din_d;
            wait_q    <= wait_d;
            req_q     <= req_d;
            done_tx_q <= done_tx_d;
            done_rx_q <= done_rx_d;
            lat_tx_q  <= lat_tx_d;
            lat_rx_q  <= lat_rx_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end
endmodule
